// File: rtl/lisnoc_def.sv
// Shared lisnoc flit definitions.
// Flit type codes and header field placement.
package lisnoc_def;

    localparam logic [1:0] PAYLOAD = 2'b00;
    localparam logic [1:0] HEADER  = 2'b01;
    localparam logic [1:0] LAST    = 2'b10;
    localparam logic [1:0] SINGLE  = 2'b11;

    // Destination occupies the top bits of the header data field
    function automatic int dest_msb(input int flit_data_width);
        return flit_data_width - 1;
    endfunction

endpackage

// File: rtl/lisnoc_flit_outreg.sv
// Single-entry valid/ready flit register.
// Accepts a new flit whenever empty or draining in the same cycle.
module lisnoc_flit_outreg #(
    parameter int width = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [width-1:0] din,
    output logic             load_ok,
    output logic [width-1:0] q,
    output logic             q_valid,
    input  logic             q_ready
);

    assign load_ok = !q_valid || q_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q       <= din;
        end else if (q_ready) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lisnoc_uni_ring_inject.sv
// Local-port packet injector for a unidirectional ring tile.
// Turns (dest, len) requests plus a word stream into lisnoc flits.
module lisnoc_uni_ring_inject
    import lisnoc_def::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ph_dest_width   = 5,
    parameter int len_width       = 8,
    parameter int cnt_width       = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [ph_dest_width-1:0]                 req_dest,
    input  logic [len_width-1:0]                     req_len,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [flit_data_width-1:0]               data_in,
    input  logic                                     data_valid,
    output logic                                     data_ready,
    output logic [flit_type_width+flit_data_width-1:0] out_flit,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [cnt_width-1:0]                     pkt_count,
    output logic                                     busy
);

    localparam int FW       = flit_type_width + flit_data_width;
    localparam int DEST_MSB = dest_msb(flit_data_width);

    typedef enum logic {
        ST_IDLE,
        ST_PAYLOAD
    } state_t;

    state_t                       state_q, state_d;
    logic [len_width-1:0]         rem_q, rem_d;
    logic [cnt_width-1:0]         pkt_count_q;
    logic [flit_data_width-1:0]   hdr;
    logic [FW-1:0]                flit_d;
    logic [flit_type_width-1:0]   out_type;
    logic                         load, load_ok, end_hs;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        load       = 1'b0;
        hdr        = '0;
        flit_d     = '0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = load_ok;
                if (req_valid && load_ok) begin
                    load = 1'b1;
                    hdr[DEST_MSB -: ph_dest_width] = req_dest;
                    hdr[len_width-1:0]             = req_len;
                    flit_d = {(req_len != '0) ? flit_type_width'(HEADER)
                                              : flit_type_width'(SINGLE), hdr};
                    rem_d  = req_len;
                    if (req_len != '0)
                        state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                data_ready = load_ok;
                if (data_valid && load_ok) begin
                    load   = 1'b1;
                    flit_d = {(rem_q == len_width'(1)) ? flit_type_width'(LAST)
                                                       : flit_type_width'(PAYLOAD),
                              data_in};
                    rem_d  = rem_q - len_width'(1);
                    if (rem_q == len_width'(1))
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    lisnoc_flit_outreg #(
        .width (FW)
    ) u_outreg (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .din     (flit_d),
        .load_ok (load_ok),
        .q       (out_flit),
        .q_valid (out_valid),
        .q_ready (out_ready)
    );

    // A packet counts as delivered once its closing flit leaves
    assign out_type = out_flit[FW-1 -: flit_type_width];
    assign end_hs   = out_valid && out_ready &&
                      (out_type == flit_type_width'(LAST) ||
                       out_type == flit_type_width'(SINGLE));

    always_ff @(posedge clk) begin
        if (rst)
            pkt_count_q <= '0;
        else if (end_hs)
            pkt_count_q <= pkt_count_q + cnt_width'(1);
    end

    assign pkt_count = pkt_count_q;
    assign busy      = (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_lisnoc_uni_ring_inject.sv
// Randomized bench for the uni-ring injector.
// Packet-level reference model predicts flits, handshakes and counters.
module tb_lisnoc_uni_ring_inject;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  req_dest = '0;
    logic [7:0]  req_len = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [33:0] out_flit;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] pkt_count;
    logic        busy;

    always #5 clk = ~clk;

    lisnoc_uni_ring_inject #(
        .flit_data_width (32),
        .flit_type_width (2),
        .ph_dest_width   (5),
        .len_width       (8),
        .cnt_width       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_dest   (req_dest),
        .req_len    (req_len),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pkt_count  (pkt_count),
        .busy       (busy)
    );

    typedef struct packed {
        logic [4:0] dest;
        logic [7:0] len;
    } req_t;

    int nvec = 0;
    int nerr = 0;

    req_t        req_q[$];
    logic [31:0] dat_q[$];
    logic [33:0] exp_q[$];
    int          words_left = 0;
    bit          ovalid = 1'b0;
    logic [15:0] exp_cnt = '0;
    int          nout, first_hs, last_hs;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet-level expectation: header/single then len words, last tagged
    task automatic add_pkt(input logic [4:0] d, input int len,
                           input bit rnd, input logic [31:0] base);
        logic [31:0] h, w;
        req_t r;
        r.dest = d;
        r.len  = 8'(len);
        req_q.push_back(r);
        h = (32'(d) << 27) | 32'(len);
        exp_q.push_back({(len == 0) ? 2'b11 : 2'b01, h});
        for (int i = 0; i < len; i++) begin
            w = rnd ? $urandom : base + 32'(i);
            dat_q.push_back(w);
            exp_q.push_back({(i == len - 1) ? 2'b10 : 2'b00, w});
        end
    endtask

    task automatic run(input int preq, input int pdat, input int prdy,
                       input int stall, input int stop_after,
                       input int max_cyc);
        int cyc = 0;
        int ndat = 0;
        bit lok, er, ed, hs, rf, df;
        logic [33:0] f;
        req_t r;
        nout = 0;
        first_hs = -1;
        last_hs = -1;
        forever begin
            @(negedge clk);
            chk("out_valid", 64'(out_valid), 64'(ovalid));
            chk("pkt_count", 64'(pkt_count), 64'(exp_cnt));
            chk("busy", 64'(busy), 64'(words_left > 0));
            if (ovalid && exp_q.size() > 0)
                chk("out_flit", 64'(out_flit), 64'(exp_q[0]));
            if (stop_after < 0 && exp_q.size() == 0 && !ovalid)
                break;
            if (cyc >= max_cyc) begin
                chk("timeout_left", 64'(exp_q.size()), 64'(0));
                break;
            end
            out_ready = ($urandom_range(99) < prdy);
            if (ovalid && nout == 0 && stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end
            if (req_q.size() > 0 && $urandom_range(99) < preq) begin
                req_valid = 1'b1;
                req_dest  = req_q[0].dest;
                req_len   = req_q[0].len;
            end else begin
                req_valid = 1'b0;
                req_dest  = 5'($urandom);
                req_len   = 8'($urandom);
            end
            if (dat_q.size() > 0 && $urandom_range(99) < pdat) begin
                data_valid = 1'b1;
                data_in    = dat_q[0];
            end else begin
                data_valid = 1'b0;
                data_in    = $urandom;
            end
            #1;
            lok = !ovalid || out_ready;
            er  = (words_left == 0) && lok;
            ed  = (words_left > 0) && lok;
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("data_ready", 64'(data_ready), 64'(ed));
            hs = ovalid && out_ready;
            if (hs) begin
                f = exp_q.pop_front();
                if (f[33:32] == 2'b10 || f[33:32] == 2'b11)
                    exp_cnt++;
                if (first_hs < 0)
                    first_hs = cyc;
                last_hs = cyc;
                nout++;
            end
            rf = req_valid && er;
            df = data_valid && ed;
            if (rf) begin
                r = req_q.pop_front();
                words_left = int'(r.len);
            end
            if (df) begin
                void'(dat_q.pop_front());
                words_left--;
                ndat++;
            end
            if (rf || df)
                ovalid = 1'b1;
            else if (out_ready)
                ovalid = 1'b0;
            cyc++;
            if (stop_after >= 0 && df && ndat == stop_after) begin
                @(posedge clk);
                break;
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_flit", 64'(out_flit), 64'(0));
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;

        // single-flit packet
        add_pkt(5'd5, 0, 1'b0, 32'h0);
        run(100, 100, 100, 0, -1, 50);

        // streaming three-word packet
        add_pkt(5'd3, 3, 1'b0, 32'hA);
        run(100, 100, 100, 0, -1, 50);
        chk("t2_thru", 64'(last_hs - first_hs), 64'(nout - 1));

        // same packet with the header stalled four cycles
        add_pkt(5'd3, 3, 1'b0, 32'hA);
        run(100, 100, 100, 4, -1, 60);

        // back-to-back packets without a bubble
        add_pkt(5'd1, 2, 1'b1, 32'h0);
        add_pkt(5'd2, 0, 1'b1, 32'h0);
        run(100, 100, 100, 0, -1, 50);
        chk("t4_thru", 64'(last_hs - first_hs), 64'(nout - 1));

        // reset in the middle of a packet
        add_pkt(5'd7, 4, 1'b0, 32'h10);
        run(100, 100, 100, 0, 2, 50);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        data_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("mid_rst_req_ready", 64'(req_ready), 64'(1));
        rst = 1'b0;
        req_q.delete();
        dat_q.delete();
        exp_q.delete();
        ovalid = 1'b0;
        words_left = 0;
        exp_cnt = '0;
        add_pkt(5'd9, 1, 1'b1, 32'h0);
        run(100, 100, 100, 0, -1, 50);

        // counter wrap
        @(negedge clk);
        force dut.pkt_count_q = 16'hFFFF;
        #1;
        release dut.pkt_count_q;
        exp_cnt = 16'hFFFF;
        add_pkt(5'd4, 0, 1'b1, 32'h0);
        run(100, 100, 100, 0, -1, 50);

        // random traffic including a maximum-length packet
        for (int i = 0; i < 40; i++) begin
            if (i == 17)
                add_pkt(5'($urandom), 255, 1'b1, 32'h0);
            else
                add_pkt(5'($urandom), int'($urandom_range(7)), 1'b1, 32'h0);
        end
        run(70, 70, 70, 0, -1, 5000);

        for (int i = 0; i < 30; i++)
            add_pkt(5'($urandom), int'($urandom_range(5)), 1'b1, 32'h0);
        run(50, 90, 40, 0, -1, 5000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
